// File: rtl/pwm_capture_pkg.sv
// Shared types and constants for the PWM period / duty-cycle capture block.
package pwm_capture_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARM,
        ST_HIGH,
        ST_LOW,
        ST_DIV,
        ST_HOLD
    } state_t;

    localparam int DUTY_SCALE      = 100;
    localparam int DUTY_W          = 8;
    // Extra numerator bits so that high_time*DUTY_SCALE cannot overflow.
    localparam int DUTY_HEADROOM_W = 7;

endpackage

// File: rtl/pwm_capture_div.sv
// Restoring unsigned divider: one quotient bit per cycle, NUM_W cycles from start to done.
module pwm_capture_div #(
    parameter int DEN_W = 24,
    parameter int NUM_W = DEN_W + 7,
    parameter int QUO_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [NUM_W-1:0] numerator,
    input  logic [DEN_W-1:0] denominator,
    output logic             done,
    output logic [QUO_W-1:0] quotient
);

    localparam int CNT_BW = $clog2(NUM_W + 1);

    logic              busy;
    logic [CNT_BW-1:0] bit_cnt;
    logic [NUM_W-1:0]  num_sr;
    logic [DEN_W-1:0]  den_r;
    logic [DEN_W-1:0]  rem;

    logic [NUM_W-1:0]  src_num;
    logic [DEN_W-1:0]  src_den;
    logic [DEN_W-1:0]  src_rem;
    logic [QUO_W-1:0]  src_quo;
    logic [DEN_W:0]    shifted;
    logic [DEN_W:0]    diff;
    logic              q_bit;
    logic [DEN_W-1:0]  rem_next;

    // The first iteration runs on the start cycle straight from the operand
    // ports, which is what makes the latency exactly NUM_W cycles.
    // NOTE: every always_comb output gets a value on every path (defaults
    // or full ternaries) so no latch can be inferred.
    always_comb begin
        src_num  = start ? numerator   : num_sr;
        src_den  = start ? denominator : den_r;
        src_rem  = start ? '0          : rem;
        src_quo  = start ? '0          : quotient;
        shifted  = {src_rem, src_num[NUM_W-1]};
        diff     = shifted - {1'b0, src_den};
        q_bit    = (shifted >= {1'b0, src_den});
        rem_next = q_bit ? diff[DEN_W-1:0] : shifted[DEN_W-1:0];
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy     <= 1'b0;
            done     <= 1'b0;
            bit_cnt  <= '0;
            num_sr   <= '0;
            den_r    <= '0;
            rem      <= '0;
            quotient <= '0;
        end else begin
            done <= 1'b0;
            if (abort) begin
                busy <= 1'b0;
            end else if (start || busy) begin
                num_sr   <= src_num << 1;
                den_r    <= src_den;
                rem      <= rem_next;
                quotient <= {src_quo[QUO_W-2:0], q_bit};
                if (start) begin
                    busy    <= 1'b1;
                    bit_cnt <= CNT_BW'(NUM_W - 1);
                end else if (bit_cnt == CNT_BW'(1)) begin
                    busy <= 1'b0;
                    done <= 1'b1;
                end else begin
                    bit_cnt <= bit_cnt - CNT_BW'(1);
                end
            end
        end
    end

endmodule

// File: rtl/pwm_capture.sv
// Measures period, high time and duty cycle of an asynchronous PWM input and
// offers each result on a valid/ready handshake; reports a stuck line via timeout.
module pwm_capture
    import pwm_capture_pkg::*;
#(
    parameter int CNT_W   = 24,
    parameter int TIMEOUT = 2**20
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              pwm_in,
    output logic [CNT_W-1:0]  period,
    output logic [CNT_W-1:0]  high_time,
    output logic [DUTY_W-1:0] duty_pct,
    output logic              meas_valid,
    input  logic              meas_ready,
    output logic              timeout,
    output logic              stuck_level
);

    localparam int               NUM_W   = CNT_W + DUTY_HEADROOM_W;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);

    logic [1:0]        sync_ff;
    logic              lvl_d;
    logic              sync_lvl;
    logic              rise;
    logic              fall;

    state_t            state;
    logic [CNT_W-1:0]  high_cnt;
    logic [CNT_W-1:0]  low_cnt;
    logic [CNT_W-1:0]  to_cnt;
    logic              to_hit;
    logic [CNT_W:0]    sum;
    logic [CNT_W-1:0]  period_sat;

    logic              div_start;
    logic              div_done;
    logic [NUM_W-1:0]  div_num;
    logic [DUTY_W-1:0] div_q;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + CNT_W'(1);
    endfunction

    // Two flops resolve metastability; the third holds the previous level.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_ff <= '0;
            lvl_d   <= 1'b0;
        end else begin
            sync_ff <= {sync_ff[0], pwm_in};
            lvl_d   <= sync_ff[1];
        end
    end

    assign sync_lvl   = sync_ff[1];
    assign rise       = sync_lvl & ~lvl_d;
    assign fall       = ~sync_lvl & lvl_d;
    assign to_hit     = (to_cnt == TO_LAST);
    assign sum        = {1'b0, high_cnt} + {1'b0, low_cnt};
    assign period_sat = sum[CNT_W] ? CNT_MAX : sum[CNT_W-1:0];
    assign div_num    = NUM_W'(high_time) * NUM_W'(DUTY_SCALE);

    pwm_capture_div #(
        .DEN_W (CNT_W),
        .NUM_W (NUM_W),
        .QUO_W (DUTY_W)
    ) u_div (
        .clk         (clk),
        .rst         (rst),
        .start       (div_start),
        .abort       (~en),
        .numerator   (div_num),
        .denominator (period),
        .done        (div_done),
        .quotient    (div_q)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            high_cnt    <= '0;
            low_cnt     <= '0;
            to_cnt      <= '0;
            div_start   <= 1'b0;
            period      <= '0;
            high_time   <= '0;
            duty_pct    <= '0;
            meas_valid  <= 1'b0;
            timeout     <= 1'b0;
            stuck_level <= 1'b0;
        end else begin
            timeout   <= 1'b0;
            div_start <= 1'b0;
            if (!en) begin
                // Results stay put; only the handshake and the FSM are dropped.
                state      <= ST_IDLE;
                meas_valid <= 1'b0;
                to_cnt     <= '0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        state  <= ST_ARM;
                        to_cnt <= '0;
                    end
                    ST_ARM: begin
                        if (rise) begin
                            high_cnt <= CNT_W'(1);
                            low_cnt  <= '0;
                            to_cnt   <= '0;
                            state    <= ST_HIGH;
                        end else if (to_hit) begin
                            timeout     <= 1'b1;
                            stuck_level <= sync_lvl;
                            to_cnt      <= '0;
                            state       <= ST_ARM;
                        end else begin
                            to_cnt <= to_cnt + CNT_W'(1);
                        end
                    end
                    ST_HIGH: begin
                        if (fall) begin
                            low_cnt <= CNT_W'(1);
                            to_cnt  <= '0;
                            state   <= ST_LOW;
                        end else if (to_hit) begin
                            timeout     <= 1'b1;
                            stuck_level <= sync_lvl;
                            to_cnt      <= '0;
                            state       <= ST_ARM;
                        end else begin
                            high_cnt <= sat_inc(high_cnt);
                            to_cnt   <= to_cnt + CNT_W'(1);
                        end
                    end
                    ST_LOW: begin
                        if (rise) begin
                            high_time <= high_cnt;
                            period    <= period_sat;
                            div_start <= 1'b1;
                            to_cnt    <= '0;
                            state     <= ST_DIV;
                        end else if (to_hit) begin
                            timeout     <= 1'b1;
                            stuck_level <= sync_lvl;
                            to_cnt      <= '0;
                            state       <= ST_ARM;
                        end else begin
                            low_cnt <= sat_inc(low_cnt);
                            to_cnt  <= to_cnt + CNT_W'(1);
                        end
                    end
                    ST_DIV: begin
                        if (div_done) begin
                            duty_pct   <= div_q;
                            meas_valid <= 1'b1;
                            state      <= ST_HOLD;
                        end
                    end
                    ST_HOLD: begin
                        // Edges are ignored here so the pending result is never overwritten.
                        if (meas_ready) begin
                            meas_valid <= 1'b0;
                            to_cnt     <= '0;
                            state      <= ST_ARM;
                        end
                    end
                    default: begin
                        state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pwm_capture.sv
// Directed bench for pwm_capture (CNT_W=16, TIMEOUT=1000) with immediate-assertion checks.
module tb_pwm_capture;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        pwm_in;
    logic        meas_ready;
    logic [15:0] period;
    logic [15:0] high_time;
    logic [7:0]  duty_pct;
    logic        meas_valid;
    logic        timeout;
    logic        stuck_level;

    int passed = 0;
    int failed = 0;
    int total  = 0;

    // Event monitor, cleared at the start of each scenario.
    int          win_cyc;
    int          valid_cyc;
    int          hs_cnt;
    int          to_pulses;
    int          to_at;
    int          unstable;
    logic        first_seen;
    logic [15:0] f_period, f_high, hs_period, hs_high;
    logic [7:0]  f_duty, hs_duty;

    pwm_capture #(
        .CNT_W   (16),
        .TIMEOUT (1000)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .pwm_in      (pwm_in),
        .period      (period),
        .high_time   (high_time),
        .duty_pct    (duty_pct),
        .meas_valid  (meas_valid),
        .meas_ready  (meas_ready),
        .timeout     (timeout),
        .stuck_level (stuck_level)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic clear_mon();
        win_cyc    = 0;
        valid_cyc  = 0;
        hs_cnt     = 0;
        to_pulses  = 0;
        to_at      = -1;
        unstable   = 0;
        first_seen = 1'b0;
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            win_cyc++;
            if (timeout === 1'b1) begin
                to_pulses++;
                to_at = win_cyc;
            end
            if (meas_valid === 1'b1) begin
                valid_cyc++;
                if (!first_seen) begin
                    first_seen = 1'b1;
                    f_period   = period;
                    f_high     = high_time;
                    f_duty     = duty_pct;
                end else if (period !== f_period || high_time !== f_high || duty_pct !== f_duty) begin
                    unstable++;
                end
                if (meas_ready === 1'b1) begin
                    hs_cnt++;
                    hs_period = period;
                    hs_high   = high_time;
                    hs_duty   = duty_pct;
                end
            end
        end
    endtask

    task automatic drive_pwm(input int h, input int l, input int reps);
        for (int r = 0; r < reps; r++) begin
            pwm_in = 1'b1;
            step(h);
            pwm_in = 1'b0;
            step(l);
        end
    endtask

    initial begin
        rst        = 1'b1;
        en         = 1'b0;
        pwm_in     = 1'b0;
        meas_ready = 1'b0;
        clear_mon();
        step(3);
        check("rst_period",     period,      0);
        check("rst_high_time",  high_time,   0);
        check("rst_duty",       duty_pct,    0);
        check("rst_valid",      meas_valid,  0);
        check("rst_timeout",    timeout,     0);
        check("rst_stuck",      stuck_level, 0);

        // 30 high / 70 low, ready always high: results are taken on the first valid cycle.
        rst        = 1'b0;
        en         = 1'b1;
        meas_ready = 1'b1;
        step(5);
        clear_mon();
        drive_pwm(30, 70, 4);
        check("p30_period",     hs_period, 100);
        check("p30_high_time",  hs_high,   30);
        check("p30_duty",       hs_duty,   30);
        check("p30_handshakes", hs_cnt,    2);
        check("p30_valid_cyc",  valid_cyc, 2);
        check("p30_no_timeout", to_pulses, 0);
        check("p30_valid_idle", meas_valid, 0);

        // 100 high / 200 low: duty floors 33.33 to 33.
        clear_mon();
        drive_pwm(100, 200, 3);
        check("p100_period",     hs_period, 300);
        check("p100_high_time",  hs_high,   100);
        check("p100_duty",       hs_duty,   33);
        check("p100_handshakes", hs_cnt,    1);

        // Line stuck high after a rising edge: HIGH entered 3 cycles after the
        // pin change, so the single pulse lands 1003 cycles after it.
        en = 1'b0;
        step(3);
        en     = 1'b1;
        pwm_in = 1'b0;
        step(5);
        clear_mon();
        pwm_in = 1'b1;
        step(2000);
        check("stuck_pulses",   to_pulses,   1);
        check("stuck_pulse_at", to_at,       1003);
        check("stuck_level",    stuck_level, 1);
        check("stuck_no_valid", valid_cyc,   0);

        // Consumer stalls for 700 cycles: result must be held and stay constant.
        pwm_in = 1'b0;
        en     = 1'b0;
        step(3);
        en         = 1'b1;
        meas_ready = 1'b0;
        step(5);
        clear_mon();
        drive_pwm(30, 70, 7);
        check("stall_period",    f_period, 100);
        check("stall_high_time", f_high,   30);
        check("stall_duty",      f_duty,   30);
        check("stall_stable",    unstable, 0);
        check("stall_held_long", (valid_cyc >= 500), 1);
        check("stall_valid_end", meas_valid, 1);
        meas_ready = 1'b1;
        pwm_in     = 1'b1;
        step(1);
        check("stall_released",  meas_valid, 0);
        clear_mon();
        step(29);
        pwm_in = 1'b0;
        step(70);
        drive_pwm(30, 70, 2);
        check("resume_handshakes", hs_cnt,    1);
        check("resume_period",     hs_period, 100);
        check("resume_high_time",  hs_high,   30);
        check("resume_duty",       hs_duty,   30);

        // Reset asserted while the divider is running (DIV entered 3 cycles after the last rise).
        en = 1'b0;
        step(2);
        en     = 1'b1;
        pwm_in = 1'b0;
        step(5);
        pwm_in = 1'b1;
        step(30);
        pwm_in = 1'b0;
        step(70);
        pwm_in = 1'b1;
        step(10);
        rst = 1'b1;
        step(1);
        check("divrst_valid",     meas_valid,  0);
        check("divrst_period",    period,      0);
        check("divrst_high_time", high_time,   0);
        check("divrst_duty",      duty_pct,    0);
        check("divrst_timeout",   timeout,     0);
        check("divrst_stuck",     stuck_level, 0);
        rst = 1'b0;
        clear_mon();
        step(30);
        check("divrst_no_done", valid_cyc, 0);

        // Produce a 300/100/33 result, then drop en in the middle of HIGH.
        en = 1'b0;
        step(2);
        en = 1'b1;
        step(2);
        pwm_in = 1'b0;
        step(20);
        clear_mon();
        drive_pwm(100, 200, 2);
        check("pre_en_handshakes", hs_cnt,    1);
        check("pre_en_period",     hs_period, 300);
        check("pre_en_duty",       hs_duty,   33);
        pwm_in = 1'b1;
        step(10);
        en = 1'b0;
        step(1);
        check("en_off_valid",     meas_valid, 0);
        check("en_off_period",    period,     300);
        check("en_off_high_time", high_time,  100);
        check("en_off_duty",      duty_pct,   33);
        clear_mon();
        step(40);
        pwm_in = 1'b0;
        step(100);
        pwm_in = 1'b1;
        step(50);
        check("idle_no_valid",  valid_cyc, 0);
        check("idle_period",    period,    300);
        check("idle_high_time", high_time, 100);
        check("idle_duty",      duty_pct,  33);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
